// File: rtl/ifetch_queue.sv
// ifetch_queue: sequential instruction fetch into a DEPTH-entry circular FIFO feeding dispatch; redirect flushes and restarts fetch.
// Latency: request pulse one cycle after the idle decision; an entry reaches the head the cycle after it is written.
// Backpressure: no request while full or while a read is outstanding; Dispatch_ren on empty is ignored.
// Optional: define IFQ_BYPASS_EN to expose a response at the head in its arrival cycle when the queue is empty.
module ifetch_queue #(
  parameter int          DEPTH    = 16,
  parameter int          PTR_W    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        Dispatch_ren,
  input  logic        Dispatch_jmp,
  input  logic [31:0] Dispatch_jmp_addr,
  output logic [31:0] ifetch_pc_4,
  output logic [31:0] ifetch_intruction,
  output logic        ifetch_empty,
  output logic        ifetch_full,
  output logic        imem_rd_en,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_data
);

  localparam logic [PTR_W:0]   L_DEPTH = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   L_CONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] L_PONE  = PTR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [31:0]      r_fetch_pc;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_rd_en;
  logic [31:0]      r_addr;
  logic [31:0]      r_mem_pc4 [DEPTH];
  logic [31:0]      r_mem_ins [DEPTH];

  logic             w_issue;
  logic             w_rsp;
  logic             w_push;
  logic             w_pop;
  logic             w_byp;
  logic             w_empty_q;
  logic             w_full_q;
  logic [31:0]      w_pc_4_nxt;

  assign w_pc_4_nxt = r_fetch_pc + 32'd4;
  assign w_empty_q  = (r_count == '0);
  assign w_full_q   = (r_count == L_DEPTH);
  // A response is only kept when it belongs to the current path.
  assign w_rsp      = (r_state == S_WAIT) && imem_valid && !Dispatch_jmp;
  assign w_pop      = Dispatch_ren && !Dispatch_jmp && !w_empty_q;

`ifdef IFQ_BYPASS_EN
  assign w_byp  = w_rsp && w_empty_q;
  // A bypassed response consumed in its arrival cycle never enters the FIFO.
  assign w_push = w_rsp && !(w_byp && Dispatch_ren);
`else
  assign w_byp  = 1'b0;
  assign w_push = w_rsp;
`endif

  assign imem_rd_en  = r_rd_en;
  assign imem_addr   = r_addr;
  assign ifetch_full = w_full_q;

  // Head presentation: bypassed response, else FIFO head, zeroed when empty.
  always_comb begin
    ifetch_pc_4       = '0;
    ifetch_intruction = '0;
    ifetch_empty      = w_empty_q;
    if (w_byp) begin
      ifetch_pc_4       = w_pc_4_nxt;
      ifetch_intruction = imem_data;
      ifetch_empty      = 1'b0;
    end else if (!w_empty_q) begin
      ifetch_pc_4       = r_mem_pc4[r_rd_ptr];
      ifetch_intruction = r_mem_ins[r_rd_ptr];
    end
  end

  // Fetch FSM next state; a request is issued only with space reserved and nothing in flight.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!Dispatch_jmp && !w_full_q) begin
          w_issue     = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (Dispatch_jmp) begin
          w_state_nxt = imem_valid ? S_IDLE : S_DROP;
        end else if (imem_valid) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DROP: begin
        // The in-flight read is stale whatever the redirect count; leave once it lands.
        if (imem_valid) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Fetch PC, request outputs, pointers and occupancy; redirect overrides push and pop.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_rd_en    <= 1'b0;
      r_addr     <= RESET_PC;
    end else begin
      r_rd_en <= w_issue;
      if (w_issue) begin
        r_addr <= r_fetch_pc;
      end
      if (Dispatch_jmp) begin
        r_fetch_pc <= Dispatch_jmp_addr;
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
        r_count    <= '0;
      end else begin
        if (w_rsp) begin
          r_fetch_pc <= w_pc_4_nxt;
        end
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + L_PONE;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + L_PONE;
        end
        if (w_push && !w_pop) begin
          r_count <= r_count + L_CONE;
        end else if (!w_push && w_pop) begin
          r_count <= r_count - L_CONE;
        end
      end
    end
  end

  // Entry storage; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem_pc4[r_wr_ptr] <= w_pc_4_nxt;
      r_mem_ins[r_wr_ptr] <= imem_data;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed table, multi-cycle corner sequences and randomized traffic against a queue-based reference.
// Latency: n/a (bench).
// Backpressure: memory model holds one outstanding read with configurable or random latency.
module tb_ifetch_queue;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        Dispatch_ren = 1'b0;
  logic        Dispatch_jmp = 1'b0;
  logic [31:0] Dispatch_jmp_addr = '0;
  logic [31:0] ifetch_pc_4;
  logic [31:0] ifetch_intruction;
  logic        ifetch_empty;
  logic        ifetch_full;
  logic        imem_rd_en;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_data;

  int vectors = 0;
  int miscompares = 0;

  ifetch_queue dut (
    .clock             (clock),
    .reset             (reset),
    .Dispatch_ren      (Dispatch_ren),
    .Dispatch_jmp      (Dispatch_jmp),
    .Dispatch_jmp_addr (Dispatch_jmp_addr),
    .ifetch_pc_4       (ifetch_pc_4),
    .ifetch_intruction (ifetch_intruction),
    .ifetch_empty      (ifetch_empty),
    .ifetch_full       (ifetch_full),
    .imem_rd_en        (imem_rd_en),
    .imem_addr         (imem_addr),
    .imem_valid        (imem_valid),
    .imem_data         (imem_data)
  );

  initial forever #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- instruction memory model ----------------
  int          lat = 1;
  bit          rand_lat = 1'b0;
  int          req_count = 0;
  int          resp_count = 0;
  logic [31:0] last_addr = '0;
  bit          m_pend = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_addr = '0;

  initial begin
    imem_valid = 1'b0;
    imem_data  = '0;
    forever begin
      @(posedge clock);
      #2;
      imem_valid = 1'b0;
      if (m_pend) begin
        m_cnt--;
        if (m_cnt == 0) begin
          imem_valid = 1'b1;
          imem_data  = m_addr ^ 32'hFFFF_0000;
          m_pend     = 1'b0;
          resp_count++;
        end
      end
      if (imem_rd_en) begin
        m_pend    = 1'b1;
        m_addr    = imem_addr;
        m_cnt     = rand_lat ? int'($urandom_range(1, 4)) : lat;
        last_addr = imem_addr;
        req_count++;
      end
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc4;
    logic [31:0] ins;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] r_fpc = '0;
  logic [31:0] r_ra = '0;
  bit          r_out = 1'b0;
  bit          r_stale = 1'b0;
  int          max_q = 0;

  initial forever begin
    @(negedge clock);
    if (reset) begin
      mq.delete();
      r_fpc   = 32'h0;
      r_out   = 1'b0;
      r_stale = 1'b0;
    end else begin
      chk("head_empty", ifetch_empty, mq.size() == 0);
      chk("head_full", ifetch_full, mq.size() == 16);
      if (mq.size() > 0) begin
        chk("head_pc_4", ifetch_pc_4, mq[0].pc4);
        chk("head_ins", ifetch_intruction, mq[0].ins);
      end else begin
        chk("head_pc_4_zero", ifetch_pc_4, 32'h0);
        chk("head_ins_zero", ifetch_intruction, 32'h0);
      end
      if (imem_rd_en) begin
        chk("req_addr", imem_addr, r_fpc);
        chk("req_single_outstanding", r_out, 1'b0);
        chk("req_space", mq.size() < 16, 1'b1);
      end
      if (Dispatch_ren && !Dispatch_jmp && mq.size() > 0) begin
        void'(mq.pop_front());
      end
      if (imem_valid && r_out) begin
        if (!r_stale && !Dispatch_jmp) begin
          mq.push_back('{pc4: r_ra + 32'd4, ins: r_ra ^ 32'hFFFF_0000});
          r_fpc = r_ra + 32'd4;
        end
        r_out = 1'b0;
      end
      if (imem_rd_en) begin
        r_out   = 1'b1;
        r_stale = 1'b0;
        r_ra    = r_fpc;
      end
      if (Dispatch_jmp) begin
        mq.delete();
        r_fpc   = Dispatch_jmp_addr;
        r_stale = r_out;
      end
      if (mq.size() > max_q) max_q = mq.size();
    end
  end

  // ---------------- helpers ----------------
  task automatic do_reset();
    reset        = 1'b1;
    Dispatch_ren = 1'b0;
    Dispatch_jmp = 1'b0;
    repeat (5) tick();
    reset     = 1'b0;
    req_count = 0;
    resp_count = 0;
  endtask

  task automatic wait_rd(input string nm, output logic [31:0] a);
    int n = 0;
    a = '0;
    while (!imem_rd_en && n < 200) begin
      tick();
      n++;
    end
    if (imem_rd_en) a = imem_addr;
    else begin
      vectors++;
      miscompares++;
      $display("FAIL %s: no imem_rd_en within 200 cycles", nm);
    end
  endtask

  task automatic wait_ne(input string nm);
    int n = 0;
    while (ifetch_empty && n < 200) begin
      tick();
      n++;
    end
    if (ifetch_empty) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: queue stayed empty for 200 cycles", nm);
    end
  endtask

  typedef struct {
    logic        ren;
    logic        exp_rd;
    logic [31:0] exp_addr;
    logic        exp_empty;
    logic [31:0] exp_pc4;
    logic [31:0] exp_ins;
    logic        exp_full;
  } vec_t;

  vec_t tbl[11];

  initial begin
    logic [31:0] a;
    int n;
    int heads;
    logic [31:0] exp_pc;

    // Cycle-exact startup with 1-cycle memory, one pop at cycle 8.
    tbl[0]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 32'h0,         1'b0};
    tbl[1]  = '{1'b0, 1'b1, 32'h0, 1'b1, 32'h0, 32'h0,         1'b0};
    tbl[2]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 32'h0,         1'b0};
    tbl[3]  = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h4, 32'hFFFF_0000, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 32'h4, 1'b0, 32'h4, 32'hFFFF_0000, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 32'h4, 1'b0, 32'h4, 32'hFFFF_0000, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 32'h4, 1'b0, 32'h4, 32'hFFFF_0000, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 32'h8, 1'b0, 32'h4, 32'hFFFF_0000, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 32'h8, 1'b0, 32'h4, 32'hFFFF_0000, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 32'h8, 1'b0, 32'h8, 32'hFFFF_0004, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 32'hC, 1'b0, 32'h8, 32'hFFFF_0004, 1'b0};

    lat = 1;
    rand_lat = 1'b0;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      Dispatch_ren = tbl[i].ren;
      @(negedge clock);
      chk($sformatf("tbl%0d_rd_en", i), imem_rd_en, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].exp_addr);
      chk($sformatf("tbl%0d_empty", i), ifetch_empty, tbl[i].exp_empty);
      chk($sformatf("tbl%0d_pc_4", i), ifetch_pc_4, tbl[i].exp_pc4);
      chk($sformatf("tbl%0d_ins", i), ifetch_intruction, tbl[i].exp_ins);
      chk($sformatf("tbl%0d_full", i), ifetch_full, tbl[i].exp_full);
      tick();
    end
    Dispatch_ren = 1'b0;

    // Fill to full, no requests while full, one pop frees a slot.
    do_reset();
    n = 0;
    while (!ifetch_full && n < 200) begin
      tick();
      n++;
    end
    chk("fill_full", ifetch_full, 1'b1);
    chk("fill_req_count", req_count, 16);
    chk("fill_last_addr", last_addr, 32'h3C);
    repeat (10) tick();
    chk("full_no_req", req_count, 16);
    chk("full_held", ifetch_full, 1'b1);
    Dispatch_ren = 1'b1;
    tick();
    Dispatch_ren = 1'b0;
    chk("pop_not_full", ifetch_full, 1'b0);
    wait_rd("after_pop", a);
    chk("after_pop_addr", a, 32'h40);

    // Redirect with simultaneous pop after three entries.
    do_reset();
    n = 0;
    while (resp_count < 3 && n < 200) begin
      tick();
      n++;
    end
    chk("jmp_prefill", resp_count, 3);
    Dispatch_jmp      = 1'b1;
    Dispatch_jmp_addr = 32'h100;
    Dispatch_ren      = 1'b1;
    tick();
    Dispatch_jmp = 1'b0;
    Dispatch_ren = 1'b0;
    chk("jmp_empty", ifetch_empty, 1'b1);
    wait_rd("jmp_req", a);
    chk("jmp_req_addr", a, 32'h100);
    wait_ne("jmp_head");
    chk("jmp_head_pc_4", ifetch_pc_4, 32'h104);
    chk("jmp_head_ins", ifetch_intruction, 32'h100 ^ 32'hFFFF_0000);

    // Redirect while waiting on a slow memory: stale response dropped.
    lat = 4;
    do_reset();
    wait_rd("drop_first", a);
    chk("drop_first_addr", a, 32'h0);
    tick();
    Dispatch_jmp      = 1'b1;
    Dispatch_jmp_addr = 32'h200;
    tick();
    Dispatch_jmp = 1'b0;
    wait_rd("drop_req", a);
    chk("drop_req_addr", a, 32'h200);
    wait_ne("drop_head");
    chk("drop_head_pc_4", ifetch_pc_4, 32'h204);

    // Continuous pop through pointer wrap.
    lat = 2;
    do_reset();
    max_q = 0;
    Dispatch_ren = 1'b1;
    exp_pc = 32'h4;
    heads = 0;
    n = 0;
    while (heads < 40 && n < 600) begin
      @(negedge clock);
      if (!ifetch_empty) begin
        chk("wrap_head_pc_4", ifetch_pc_4, exp_pc);
        exp_pc = exp_pc + 32'd4;
        heads++;
      end
      tick();
      n++;
    end
    Dispatch_ren = 1'b0;
    chk("wrap_heads", heads, 40);
    chk("wrap_max_count", max_q, 1);

    // One-cycle reset while a read is in flight.
    lat = 2;
    do_reset();
    n = 0;
    while (req_count < 3 && n < 200) begin
      tick();
      n++;
    end
    chk("rst_prefill", req_count, 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk("rst_empty", ifetch_empty, 1'b1);
    chk("rst_full", ifetch_full, 1'b0);
    chk("rst_pc_4", ifetch_pc_4, 32'h0);
    chk("rst_ins", ifetch_intruction, 32'h0);
    chk("rst_rd_en", imem_rd_en, 1'b0);
    chk("rst_addr", imem_addr, 32'h0);
    tick();
    wait_rd("rst_req", a);
    chk("rst_req_addr", a, 32'h0);
    wait_ne("rst_head");
    chk("rst_head_pc_4", ifetch_pc_4, 32'h4);
    chk("rst_head_ins", ifetch_intruction, 32'hFFFF_0000);

    // Randomized traffic, first redirect lands at the top of the address space.
    rand_lat = 1'b1;
    do_reset();
    n = 0;
    for (int c = 0; c < 1200; c++) begin
      if (c < 600) Dispatch_ren = ($urandom_range(0, 3) == 0);
      else         Dispatch_ren = ($urandom_range(0, 3) != 0);
      Dispatch_jmp = ($urandom_range(0, 29) == 0);
      if (Dispatch_jmp) begin
        Dispatch_jmp_addr = (n == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_0FFC);
        n++;
      end
      tick();
    end
    Dispatch_ren = 1'b0;
    Dispatch_jmp = 1'b0;
    repeat (10) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
